ticket_issue_arbiter: RTL
=========================

// Module: ticket_issue_arbiter
// PURPOSE
//   Shares one ticket printer and one change dispenser between N_REQ ticket counters.
//   - Each counter's coin FSM raises req once the fare is paid. It supplies a station code and the change owed.
//   - This block grants counters round-robin, sequences the job (print, then change), and acknowledges the counter.
//   - Sits between the per-counter ticket FSMs and the shared printer/dispenser.
// PARAMETERS
//   N_REQ    3   number of ticket counters (2..4)
//   CHG_W    3   width of change value (matches counter change output)
//   TIMEOUT  16  max cycles to wait for prn_done before aborting the job (>=2)
// PORTS
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous, active-low reset
//   req        in   N_REQ        req[i]=1: counter i has a paid ticket pending; held until ack/nak
//   stn        in   2*N_REQ      station code of counter i at [2i+1:2i]; 1..3 valid, 0 invalid
//   chg        in   CHG_W*N_REQ  change owed by counter i at [CHG_W*i +: CHG_W]
//   prn_done   in   1            printer completion pulse
//   ack        out  N_REQ        one-cycle pulse: counter i's ticket issued
//   nak        out  N_REQ        one-cycle pulse: counter i's job rejected (bad station or timeout)
//   prn_start  out  1            one-cycle pulse to printer
//   prn_stn    out  2            latched station code; valid from prn_start until the job ends
//   chg_vld    out  1            one-cycle pulse to dispenser
//   chg_val    out  CHG_W        change amount; valid with chg_vld, 0 otherwise
//   busy       out  1            1 in every state except IDLE
//   gnt_id     out  2            index of the counter being served; 0 when IDLE
//   err        out  1            sticky; set on a printer timeout, cleared only by reset
// BEHAVIOUR
//   Reset:
//   - All outputs 0; FSM=IDLE; rr_ptr=0; timeout counter=0.
//   - Reset is effective immediately, including mid-job. The job is dropped and no ack/nak is sent.
//   FSM states: IDLE, START, WAIT, CHG, DONE. All outputs are registered.
//   IDLE:
//   - If any req bit is set, select the first set bit searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
//   - Latch id, stn[id] and chg[id]; go to START. Otherwise stay in IDLE.
//   START:
//   - If the latched stn==0: no prn_start; set the reject flag; go to DONE.
//   - Otherwise: prn_start=1 for this cycle; clear the counter; go to WAIT.
//   WAIT:
//   - prn_done=1: go to CHG. If prn_done and timeout coincide, done wins.
//   - Otherwise increment the counter.
//   - Counter reaches TIMEOUT-1: set err, set the reject flag, go to DONE (no change dispensed).
//   CHG:
//   - If latched chg!=0: chg_vld=1 and chg_val=chg for this cycle. If chg==0, no pulse.
//   - Always go to DONE; one cycle in CHG either way.
//   DONE:
//   - Pulse ack[id], or nak[id] if the reject flag is set.
//   - rr_ptr = (id+1) mod N_REQ; clear the reject flag; go to IDLE.
//   Latency:
//   - req sampled in IDLE at cycle 0 -> prn_start at cycle 1.
//   - prn_done at cycle k -> chg_vld at k+1 -> ack at k+2.
//   - Bad station: nak at cycle 2.
//   Handshake:
//   - A counter drops req in the cycle after ack/nak.
//   - req is sampled only in IDLE. Dropping req mid-job is ignored; the latched job completes.
//   - stn and chg are sampled only at grant. Later changes do not affect the current job.
//   - prn_done outside WAIT is ignored.
//   - At most one ack/nak bit is set per cycle; ack and nak are never both set.
//   - prn_stn holds its value through WAIT/CHG/DONE; it is 0 in IDLE.
//   Fairness: with all req held, grants rotate 0,1,2,0...; no counter waits more than N_REQ-1 jobs.
// TESTING
//   1 Single job: req=001, stn0=2, chg0=3, prn_done 3 cycles after prn_start
//     -> prn_stn=2; chg_vld with chg_val=3; ack=001; busy drops the cycle after ack.
//   2 Contention: req=111 held; each counter drops its req after its ack
//     -> grant order 0,1,2; three ack pulses, each one-hot; rr_ptr ends at 0.
//   3 Invalid station: req=010, stn1=0
//     -> no prn_start; nak=010 at cycle 2; err stays 0.
//   4 Timeout: req=100, prn_done never asserted
//     -> nak=100 TIMEOUT cycles after prn_start; err=1 held; no chg_vld.
//     -> A following valid job still completes with ack; err stays 1.
//   5 Reset mid-job: deassert rst during WAIT
//     -> all outputs 0 immediately; no ack.
//     -> After release, a pending req is granted from index 0.
//   6 Zero change, plus prn_done arriving on the timeout cycle
//     -> no chg_vld; ack (not nak) at k+2; err stays 0.

Source files
------------

// File: rtl/ticket_issue_arbiter.sv
// ticket_issue_arbiter: round-robin share of one ticket printer and one change dispenser among N_REQ counters
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   req_i/stn_i/chg_i          per-counter request, station code (2 bits each), change owed (CHG_W each)
//   prn_done_i                 printer completion pulse
//   ack_o/nak_o                one-cycle per-counter issue / reject pulses
//   prn_start_o/prn_stn_o      printer start pulse and latched station code
//   chg_vld_o/chg_val_o        dispenser pulse and amount
//   busy_o/gnt_id_o/err_o      not idle, counter being served, sticky printer timeout
module ticket_issue_arbiter #(
    parameter int N_REQ   = 3,
    parameter int CHG_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [2*N_REQ-1:0]     stn_i,
    input  logic [CHG_W*N_REQ-1:0] chg_i,
    input  logic                   prn_done_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       nak_o,
    output logic                   prn_start_o,
    output logic [1:0]             prn_stn_o,
    output logic                   chg_vld_o,
    output logic [CHG_W-1:0]       chg_val_o,
    output logic                   busy_o,
    output logic [1:0]             gnt_id_o,
    output logic                   err_o
);
    localparam int CNT_W = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, START, WAIT, CHG, DONE} state_t;
    state_t             state_q, state_d;
    logic [1:0]         id_q, id_d, rr_q, rr_d, stn_q, stn_d, pick, stn_sel;
    logic [CHG_W-1:0]   chg_q, chg_d, chg_sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rej_q, rej_d, err_q, err_d;
    logic [2:0]         idx;
    logic [N_REQ-1:0]   oh;
    logic [N_REQ-1:0]   ack_q, ack_d, nak_q, nak_d;
    logic               prn_start_q, prn_start_d, chg_vld_q, chg_vld_d, busy_q, busy_d;
    logic [1:0]         prn_stn_q, prn_stn_d, gnt_id_q, gnt_id_d;
    logic [CHG_W-1:0]   chg_val_q, chg_val_d;
    // Walk from the farthest candidate to the nearest so the one closest to rr_q wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + 3'(k);
            idx = (idx >= 3'(N_REQ)) ? idx - 3'(N_REQ) : idx;
            if (req_i[idx[1:0]]) pick = idx[1:0];
        end
    end
    always_comb begin
        stn_sel = '0;
        chg_sel = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick == 2'(j)) begin
                stn_sel = stn_i[2*j +: 2];
                chg_sel = chg_i[CHG_W*j +: CHG_W];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        stn_d   = stn_q;
        chg_d   = chg_q;
        rej_d   = rej_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (|req_i) begin
                state_d = START;
                id_d    = pick;
                stn_d   = stn_sel;
                chg_d   = chg_sel;
            end
            START: begin
                state_d = (stn_q == 2'd0) ? DONE : WAIT;
                rej_d   = (stn_q == 2'd0);
                cnt_d   = '0;
            end
            // Checking one step early makes the abort land exactly TIMEOUT cycles after prn_start.
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (prn_done_i) begin
                    state_d = CHG;
                end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                    state_d = DONE;
                    rej_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            CHG:  state_d = DONE;
            DONE: begin
                state_d = IDLE;
                rej_d   = 1'b0;
                rr_d    = (id_q == 2'(N_REQ - 1)) ? 2'd0 : id_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        oh          = {{(N_REQ-1){1'b0}}, 1'b1} << id_d;
        busy_d      = (state_d != IDLE);
        gnt_id_d    = busy_d ? id_d : 2'd0;
        prn_stn_d   = busy_d ? stn_d : 2'd0;
        prn_start_d = (state_d == START) && (stn_d != 2'd0);
        chg_vld_d   = (state_d == CHG) && (chg_d != '0);
        chg_val_d   = chg_vld_d ? chg_d : '0;
        ack_d       = (state_d == DONE && !rej_d) ? oh : '0;
        nak_d       = (state_d == DONE && rej_d) ? oh : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            stn_q       <= '0;
            chg_q       <= '0;
            rej_q       <= 1'b0;
            cnt_q       <= '0;
            rr_q        <= '0;
            err_q       <= 1'b0;
            ack_q       <= '0;
            nak_q       <= '0;
            prn_start_q <= 1'b0;
            prn_stn_q   <= '0;
            chg_vld_q   <= 1'b0;
            chg_val_q   <= '0;
            busy_q      <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            stn_q       <= stn_d;
            chg_q       <= chg_d;
            rej_q       <= rej_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            nak_q       <= nak_d;
            prn_start_q <= prn_start_d;
            prn_stn_q   <= prn_stn_d;
            chg_vld_q   <= chg_vld_d;
            chg_val_q   <= chg_val_d;
            busy_q      <= busy_d;
            gnt_id_q    <= gnt_id_d;
        end
    end
    assign ack_o       = ack_q;
    assign nak_o       = nak_q;
    assign prn_start_o = prn_start_q;
    assign prn_stn_o   = prn_stn_q;
    assign chg_vld_o   = chg_vld_q;
    assign chg_val_o   = chg_val_q;
    assign busy_o      = busy_q;
    assign gnt_id_o    = gnt_id_q;
    assign err_o       = err_q;
endmodule
